// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM master and its wait counter.
package sram_pkg;

  localparam int unsigned SRAM_DATA_W = 32;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StWait,
    StResp
  } sram_state_e;

endpackage

// File: rtl/sram_wait_cnt.sv
// 4-bit wait-state counter: parallel load, saturating decrement, zero flag.
module sram_wait_cnt
  import sram_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_master.sv
// Single-outstanding request/response bridge to an asynchronous SRAM with fixed wait states.
// Optional alignment rejection enabled by defining SRAM_MASTER_ALIGN_CHECK_EN.
module sram_master
  import sram_pkg::*;
#(
  parameter int unsigned LAT_CYCLES = 2,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [SRAM_DATA_W-1:0] req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [SRAM_DATA_W-1:0] resp_rdata,
  output logic                   resp_err,
  output logic                   cs,
  output logic                   oe,
  output logic                   we,
  output logic [31:0]            addr,
  output logic [SRAM_DATA_W-1:0] din,
  input  logic [SRAM_DATA_W-1:0] dout
);

  if (LAT_CYCLES < 1 || LAT_CYCLES > 15) begin : g_lat_check
    $error("sram_master: LAT_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(LAT_CYCLES - 1);

  sram_state_e state_q;
  logic        we_q;
  logic        cnt_zero;
  logic        misaligned;

`ifdef SRAM_MASTER_ALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  sram_wait_cnt u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == StSetup),
    .load_val (WaitLoad),
    .dec      (state_q == StWait),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cs         <= 1'b0;
      oe         <= 1'b0;
      we         <= 1'b0;
      addr       <= '0;
      din        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (misaligned) begin
              // Rejected without touching the SRAM pins.
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state_q <= StSetup;
              we_q    <= req_we;
              addr    <= 32'(req_addr);
              din     <= req_wdata;
              cs      <= 1'b1;
              oe      <= ~req_we;
              we      <= 1'b0;
            end
          end
        end
        StSetup: begin
          // Write strobe only rises after a full cycle of address setup.
          we      <= we_q;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_zero) begin
            state_q    <= StResp;
            cs         <= 1'b0;
            oe         <= 1'b0;
            we         <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? '0 : dout;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q    <= StIdle;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master: LAT_CYCLES=2 instance with an SRAM model, plus LAT 1 and 15.
module tb_sram_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  resp_ready = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  wire  [2:0]  req_ready, resp_valid, resp_err, cs, oe, we;
  wire  [31:0] resp_rdata [3];
  wire  [31:0] addr [3];
  wire  [31:0] din [3];
  logic [31:0] dout [3];
  logic [31:0] mem [256];

  int          n_checks = 0;
  int          n_pass = 0;
  int          lat;
  logic [2:0]  setup_pins;
  logic [31:0] setup_addr;
  logic        cs_seen, we_seen, addr_moved, stray;

  always #5 clk = ~clk;

  always_comb begin
    dout[0] = mem[addr[0][7:0]];
    dout[1] = 32'hA5A5_0001;
    dout[2] = 32'hCAFE_0015;
  end

  always @(posedge clk) begin
    if (cs[0] && we[0]) mem[addr[0][7:0]] <= din[0];
  end

  sram_master #(.LAT_CYCLES(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .cs(cs[0]), .oe(oe[0]), .we(we[0]), .addr(addr[0]),
    .din(din[0]), .dout(dout[0])
  );

  sram_master #(.LAT_CYCLES(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .cs(cs[1]), .oe(oe[1]), .we(we[1]), .addr(addr[1]),
    .din(din[1]), .dout(dout[1])
  );

  sram_master #(.LAT_CYCLES(15)) u_dut_l15 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]), .cs(cs[2]), .oe(oe[2]), .we(we[2]), .addr(addr[2]),
    .din(din[2]), .dout(dout[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one request on instance k; returns with the response pending (lat = edges after accept).
  task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_we       = w;
    req_addr     = a;
    req_wdata    = d;
    req_valid[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    setup_pins   = {cs[k], oe[k], we[k]};
    setup_addr   = addr[k];
    cs_seen      = cs[k];
    we_seen      = 1'b0;
    addr_moved   = 1'b0;
    lat          = 0;
    while (!resp_valid[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!resp_valid[k]) begin
        cs_seen = cs_seen | cs[k];
        we_seen = we_seen | we[k];
        if (addr[k] !== setup_addr) addr_moved = 1'b1;
      end
    end
  endtask

  task automatic consume(input int k);
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEAD_BEEF;
    mem[8'h13] = 32'h1313_1313;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_req_ready", 32'(req_ready[0]), 32'h1);
    check("rst_resp_valid", 32'(resp_valid[0]), 32'h0);
    check("rst_resp_rdata", resp_rdata[0], 32'h0);
    check("rst_resp_err", 32'(resp_err[0]), 32'h0);
    check("rst_pins", 32'({cs[0], oe[0], we[0]}), 32'h0);
    check("rst_addr", addr[0], 32'h0);
    check("rst_din", din[0], 32'h0);

    access(0, 1'b0, 32'h10, 32'h0);
    check("ld10_latency", 32'(lat), 32'd3);
    check("ld10_rdata", resp_rdata[0], 32'hDEAD_BEEF);
    check("ld10_err", 32'(resp_err[0]), 32'h0);
    check("ld10_setup_pins", 32'(setup_pins), 32'b110);
    check("ld10_addr", setup_addr, 32'h10);
    check("ld10_addr_stable", 32'(addr_moved), 32'h0);
    check("ld10_resp_ready", 32'(req_ready[0]), 32'h0);
    consume(0);
    check("ld10_done_valid", 32'(resp_valid[0]), 32'h0);
    check("ld10_done_ready", 32'(req_ready[0]), 32'h1);

    access(0, 1'b1, 32'h20, 32'h1234_5678);
    check("st20_latency", 32'(lat), 32'd3);
    check("st20_setup_pins", 32'(setup_pins), 32'b100);
    check("st20_we_in_wait", 32'(we_seen), 32'h1);
    check("st20_din", din[0], 32'h1234_5678);
    check("st20_rdata", resp_rdata[0], 32'h0);
    consume(0);
    access(0, 1'b0, 32'h20, 32'h0);
    check("ld20_rdata", resp_rdata[0], 32'h1234_5678);
    consume(0);

    access(0, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid[0]), 32'h1);
      check("hold_rdata", resp_rdata[0], 32'hDEAD_BEEF);
      check("hold_req_ready", 32'(req_ready[0]), 32'h0);
    end
    consume(0);

    // Abort a load in its first WAIT cycle.
    req_we = 1'b0; req_addr = 32'h10; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_pins", 32'({cs[0], oe[0], we[0]}), 32'h0);
    check("abort_valid", 32'(resp_valid[0]), 32'h0);
    check("abort_ready", 32'(req_ready[0]), 32'h1);
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      stray = stray | resp_valid[0] | cs[0];
    end
    check("abort_no_stray", 32'(stray), 32'h0);

    access(0, 1'b0, 32'h13, 32'h0);
`ifdef SRAM_MASTER_ALIGN_CHECK_EN
    check("ua13_latency", 32'(lat), 32'd0);
    check("ua13_err", 32'(resp_err[0]), 32'h1);
    check("ua13_rdata", resp_rdata[0], 32'h0);
    check("ua13_cs_seen", 32'(cs_seen), 32'h0);
`else
    check("ua13_latency", 32'(lat), 32'd3);
    check("ua13_err", 32'(resp_err[0]), 32'h0);
    check("ua13_rdata", resp_rdata[0], 32'h1313_1313);
    check("ua13_addr", setup_addr, 32'h13);
`endif
    consume(0);

    for (int i = 0; i < 2; i++) begin
      access(1, 1'b0, 32'h40, 32'h0);
      check("lat1_latency", 32'(lat), 32'd2);
      check("lat1_rdata", resp_rdata[1], 32'hA5A5_0001);
      consume(1);
    end
    for (int i = 0; i < 2; i++) begin
      access(2, 1'b0, 32'h44, 32'h0);
      check("lat15_latency", 32'(lat), 32'd16);
      check("lat15_rdata", resp_rdata[2], 32'hCAFE_0015);
      consume(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
